// File: rtl/hazard_control_unit.sv
// Pipeline hazard sequencer: load-use, branch flush, mul/div and MEM wait stalls.
// Optional perf counters enabled with HAZARD_PERF_EN.
module hazard_control_unit #(
    parameter int MD_LATENCY  = 4,
    parameter int MEM_TIMEOUT = 255,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rstN,
    input  logic [4:0]       idRs,
    input  logic [4:0]       idRt,
    input  logic             exMemRead,
    input  logic [4:0]       exRd,
    input  logic             exBranchTaken,
    input  logic             exMdStart,
    input  logic             memReq,
    input  logic             memReady,
    output logic             pcWrite,
    output logic             ifIdWrite,
    output logic             ifIdFlush,
    output logic             idExWrite,
    output logic             idExBubble,
    output logic             exMemWrite,
    output logic             exMemBubble,
    output logic             memWbBubble,
    output logic             mdBusy,
    output logic             memErr,
    output logic [CNT_W-1:0] stallCycles,
    output logic [CNT_W-1:0] flushCount
);

    localparam int MDW  = $clog2(MD_LATENCY + 1);
    localparam int MEMW = $clog2(MEM_TIMEOUT + 1);
    localparam logic [MDW-1:0]  MD_INIT = MDW'(MD_LATENCY - 2);
    localparam logic [MEMW-1:0] MEM_TO  = MEMW'(MEM_TIMEOUT);

    typedef enum logic [1:0] {
        RUN,
        MD_WAIT,
        MEM_WAIT
    } state_e;

    state_e          state_q, state_d;
    logic [MDW-1:0]  mdCnt_q, mdCnt_d;
    logic [MEMW-1:0] memCnt_q, memCnt_d;
    logic            memErr_q, memErr_d;
    logic            loadUse;

    assign loadUse = exMemRead && (exRd != 5'd0) &&
                     ((exRd == idRs) || (exRd == idRt));
    assign memErr  = memErr_q;

    always_ff @(posedge clk) begin
        if (!rstN) begin
            state_q  <= RUN;
            mdCnt_q  <= '0;
            memCnt_q <= '0;
            memErr_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            mdCnt_q  <= mdCnt_d;
            memCnt_q <= memCnt_d;
            memErr_q <= memErr_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        mdCnt_d     = mdCnt_q;
        memCnt_d    = memCnt_q;
        memErr_d    = memErr_q;
        pcWrite     = 1'b1;
        ifIdWrite   = 1'b1;
        ifIdFlush   = 1'b0;
        idExWrite   = 1'b1;
        idExBubble  = 1'b0;
        exMemWrite  = 1'b1;
        exMemBubble = 1'b0;
        memWbBubble = 1'b0;
        mdBusy      = 1'b0;
        if (!rstN) begin
            pcWrite     = 1'b0;
            ifIdWrite   = 1'b0;
            ifIdFlush   = 1'b1;
            idExWrite   = 1'b0;
            idExBubble  = 1'b1;
            exMemWrite  = 1'b0;
            exMemBubble = 1'b1;
            memWbBubble = 1'b1;
        end else begin
            unique case (state_q)
                RUN: begin
                    if (memReq && !memReady) begin
                        pcWrite     = 1'b0;
                        ifIdWrite   = 1'b0;
                        idExWrite   = 1'b0;
                        exMemWrite  = 1'b0;
                        memWbBubble = 1'b1;
                        state_d     = MEM_WAIT;
                        memCnt_d    = MEMW'(1);
                    end else if (exMdStart && (MD_LATENCY > 1)) begin
                        pcWrite     = 1'b0;
                        ifIdWrite   = 1'b0;
                        idExWrite   = 1'b0;
                        exMemBubble = 1'b1;
                        mdBusy      = 1'b1;
                        state_d     = MD_WAIT;
                        mdCnt_d     = MD_INIT;
                    end else if (exBranchTaken) begin
                        ifIdFlush  = 1'b1;
                        idExBubble = 1'b1;
                    end else if (loadUse) begin
                        pcWrite    = 1'b0;
                        ifIdWrite  = 1'b0;
                        idExBubble = 1'b1;
                    end
                end
                MD_WAIT: begin
                    if (mdCnt_q == '0) begin
                        state_d = RUN;
                    end else begin
                        pcWrite     = 1'b0;
                        ifIdWrite   = 1'b0;
                        idExWrite   = 1'b0;
                        exMemBubble = 1'b1;
                        mdBusy      = 1'b1;
                        mdCnt_d     = mdCnt_q - MDW'(1);
                    end
                end
                MEM_WAIT: begin
                    if (memReady) begin
                        state_d  = RUN;
                        memCnt_d = '0;
                    end else if (memCnt_q == MEM_TO) begin
                        // Give up on the access; release so the core can trap.
                        memErr_d = 1'b1;
                        state_d  = RUN;
                        memCnt_d = '0;
                    end else begin
                        pcWrite     = 1'b0;
                        ifIdWrite   = 1'b0;
                        idExWrite   = 1'b0;
                        exMemWrite  = 1'b0;
                        memWbBubble = 1'b1;
                        memCnt_d    = memCnt_q + MEMW'(1);
                    end
                end
                default: state_d = RUN;
            endcase
        end
    end

`ifdef HAZARD_PERF_EN
    logic [CNT_W-1:0] stall_q, stall_d;
    logic [CNT_W-1:0] flush_q, flush_d;

    always_comb begin
        stall_d = stall_q;
        flush_d = flush_q;
        if (!pcWrite && (stall_q != '1)) stall_d = stall_q + CNT_W'(1);
        if (ifIdFlush && (flush_q != '1)) flush_d = flush_q + CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (!rstN) begin
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            stall_q <= stall_d;
            flush_q <= flush_d;
        end
    end

    assign stallCycles = stall_q;
    assign flushCount  = flush_q;
`else
    assign stallCycles = '0;
    assign flushCount  = '0;
`endif

endmodule

// File: tb/tb_hazard_control_unit.sv
// Directed bench for hazard_control_unit (MD_LATENCY=4, MEM_TIMEOUT=8).
// Control bundle order: pc,ifW,ifF,idW,idB,exW,exB,wbB,md.
module tb_hazard_control_unit;

    logic        clk = 1'b0;
    logic        rstN;
    logic [4:0]  idRs, idRt, exRd;
    logic        exMemRead, exBranchTaken, exMdStart, memReq, memReady;
    logic        pcWrite, ifIdWrite, ifIdFlush, idExWrite, idExBubble;
    logic        exMemWrite, exMemBubble, memWbBubble, mdBusy, memErr;
    logic [31:0] stallCycles, flushCount;
    logic [8:0]  ctl;
    int          n_chk = 0;
    int          n_pass = 0;

    localparam logic [8:0] C_DEF = 9'b110101000;
    localparam logic [8:0] C_RST = 9'b001010110;
    localparam logic [8:0] C_LU  = 9'b000111000;
    localparam logic [8:0] C_BR  = 9'b111111000;
    localparam logic [8:0] C_MD  = 9'b000001101;
    localparam logic [8:0] C_MEM = 9'b000000010;

    hazard_control_unit #(
        .MD_LATENCY (4),
        .MEM_TIMEOUT(8),
        .CNT_W      (32)
    ) dut (
        .clk          (clk),
        .rstN         (rstN),
        .idRs         (idRs),
        .idRt         (idRt),
        .exMemRead    (exMemRead),
        .exRd         (exRd),
        .exBranchTaken(exBranchTaken),
        .exMdStart    (exMdStart),
        .memReq       (memReq),
        .memReady     (memReady),
        .pcWrite      (pcWrite),
        .ifIdWrite    (ifIdWrite),
        .ifIdFlush    (ifIdFlush),
        .idExWrite    (idExWrite),
        .idExBubble   (idExBubble),
        .exMemWrite   (exMemWrite),
        .exMemBubble  (exMemBubble),
        .memWbBubble  (memWbBubble),
        .mdBusy       (mdBusy),
        .memErr       (memErr),
        .stallCycles  (stallCycles),
        .flushCount   (flushCount)
    );

    always #5 clk = ~clk;

    assign ctl = {pcWrite, ifIdWrite, ifIdFlush, idExWrite, idExBubble,
                  exMemWrite, exMemBubble, memWbBubble, mdBusy};

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h exp %0h", tag, got, exp);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic perf(input string tag, input int st, input int fl);
`ifdef HAZARD_PERF_EN
        chk({tag, "_stall"}, stallCycles, st);
        chk({tag, "_flush"}, flushCount, fl);
`else
        chk({tag, "_stall"}, stallCycles, 0);
        chk({tag, "_flush"}, flushCount, 0);
`endif
    endtask

    initial begin
        rstN = 1'b0; idRs = 0; idRt = 0; exRd = 0;
        exMemRead = 0; exBranchTaken = 0; exMdStart = 0;
        memReq = 0; memReady = 0;
        #1;
        chk("rst_ctl", ctl, C_RST);
        cyc();
        chk("rst_ctl2", ctl, C_RST);
        chk("rst_err", memErr, 0);
        perf("rst", 0, 0);
        rstN = 1'b1; #1;
        chk("def", ctl, C_DEF);
        cyc();

        exMemRead = 1; exRd = 5; idRs = 5; #1;
        chk("lu_rs", ctl, C_LU);
        cyc();
        exMemRead = 0; exRd = 0; idRs = 0; #1;
        chk("lu_once", ctl, C_DEF);
        cyc();
        exMemRead = 1; exRd = 7; idRt = 7; #1;
        chk("lu_rt", ctl, C_LU);
        cyc();
        exRd = 0; idRs = 0; idRt = 0; #1;
        chk("lu_x0", ctl, C_DEF);
        cyc();
        exMemRead = 0; exRd = 5; idRs = 5; #1;
        chk("lu_noload", ctl, C_DEF);
        cyc();

        exBranchTaken = 1; exMemRead = 1; exRd = 3; idRt = 3; idRs = 0; #1;
        chk("br_lu", ctl, C_BR);
        cyc();
        exBranchTaken = 0; exMemRead = 0; exRd = 0; idRt = 0; #1;
        perf("br", 2, 1);

        exMdStart = 1; #1;
        chk("md1", ctl, C_MD);
        cyc();
        chk("md2", ctl, C_MD);
        cyc();
        chk("md3", ctl, C_MD);
        cyc();
        chk("md_rel", ctl, C_DEF);
        perf("md", 5, 1);
        exMdStart = 0;
        cyc();
        chk("md_after", ctl, C_DEF);

        memReq = 1; memReady = 0; exMdStart = 1; exBranchTaken = 1; #1;
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("mem%0d", i), ctl, C_MEM);
            cyc();
        end
        exBranchTaken = 0; memReady = 1; #1;
        chk("mem_rel", ctl, C_DEF);
        cyc();
        memReq = 0; memReady = 0; #1;
        chk("mem_md1", ctl, C_MD);
        cyc();
        chk("mem_md2", ctl, C_MD);
        cyc();
        chk("mem_md3", ctl, C_MD);
        cyc();
        chk("mem_mdrel", ctl, C_DEF);
        exMdStart = 0;
        cyc();
        perf("mem", 13, 1);
        chk("mem_noerr", memErr, 0);

        memReq = 1; memReady = 0; #1;
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("to%0d", i), ctl, C_MEM);
            cyc();
        end
        chk("to_rel", ctl, C_DEF);
        chk("to_err0", memErr, 0);
        cyc();
        chk("to_err1", memErr, 1);
        chk("to_run", ctl, C_MEM);
        perf("to", 21, 1);
        memReq = 0; #1;
        chk("to_def", ctl, C_DEF);
        cyc();
        chk("to_sticky", memErr, 1);

        exMdStart = 1; #1;
        cyc();
        exMdStart = 0; #1;
        chk("rmd_busy", ctl, C_MD);
        rstN = 1'b0; #1;
        chk("rmd_rst", ctl, C_RST);
        cyc();
        rstN = 1'b1; #1;
        chk("rmd_def", ctl, C_DEF);
        chk("rmd_err", memErr, 0);
        perf("rmd", 0, 0);
        cyc();
        chk("rmd_def2", ctl, C_DEF);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got running exp finished");
        $fatal(1);
    end

endmodule
